// File: rtl/div_radix2_pkg.sv
// div_radix2_pkg
//   Shared definitions for the radix-2 restoring divider.
//   - divState_e : controller state encoding (IDLE / BUSY / DONE)
//   - DIV_ITER   : number of restoring iterations (one per quotient bit)
//   - CNT_W      : width of the iteration counter
package div_radix2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } divState_e;

  localparam int DIV_ITER = 32;
  localparam int CNT_W    = $clog2(DIV_ITER);

endpackage

// File: rtl/div_radix2_if.sv
// div_radix2_if
//   Request/response bundle between the EX stage and the divider.
//   Ports (as seen from the divider, modport slave):
//     start  in   divide request (already gated by flush in EX)
//     sign   in   1 = signed DIV, 0 = unsigned DIVU
//     a, b   in   dividend / divisor
//     cancel in   abort (exception / flush)
//     ack    in   EX advances, consumes a finished result
//     stall  out  hold IF/ID/EX while a divide is pending
//     ready  out  result valid
//     result out  {remainder, quotient} -> {HI, LO}
//   modport master is the EX-stage side (drives requests, reads results).
interface div_radix2_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               sign;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               cancel;
  logic               ack;
  logic               stall;
  logic               ready;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, sign, a, b, cancel, ack,
    input  stall, ready, result
  );

  modport slave (
    input  start, sign, a, b, cancel, ack,
    output stall, ready, result
  );
endinterface

// File: rtl/div_radix2.sv
// div_radix2
//   Multi-cycle radix-2 restoring divider for DIV / DIVU.
//   Operands are converted to magnitudes on acceptance, 32 restoring steps
//   produce the unsigned quotient/remainder, and the signs are applied on
//   the final step. Fixed latency, independent of operand values.
//   Ports:
//     clk  in  rising-edge clock
//     rst  in  asynchronous reset, active-low
//     bus  div_radix2_if.slave (start/sign/a/b/cancel/ack in,
//          stall/ready/result out)
module div_radix2
  import div_radix2_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  div_radix2_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  divState_e          stateReg, stateNext;
  logic [CNT_W-1:0]   iterCnt;
  logic [2*WIDTH:0]   remQuo;     // {rem[WIDTH:0], quo[WIDTH-1:0]}
  logic [WIDTH-1:0]   divisor;
  logic               quoNeg;
  logic               remNeg;

  logic               accept;
  logic               lastIter;
  logic [WIDTH-1:0]   absA, absB;
  logic [WIDTH+1:0]   trial;
  logic [2*WIDTH:0]   stepNext;
  logic [WIDTH-1:0]   quoFix, remFix;
  logic               stallComb, readyComb;

  assign accept   = bus.start & ~bus.cancel;
  assign lastIter = (iterCnt == CNT_W'(DIV_ITER - 1));

  // Magnitudes; a negative value is only reinterpreted for signed requests.
  assign absA = (bus.sign && bus.a[WIDTH-1]) ? (~bus.a + ONE) : bus.a;
  assign absB = (bus.sign && bus.b[WIDTH-1]) ? (~bus.b + ONE) : bus.b;

  // The shifted partial remainder is {rem, quo MSB}. The stored remainder is
  // always below the divisor, so its top bit is zero and the top bit of the
  // difference is a clean borrow flag.
  assign trial = remQuo[2*WIDTH:WIDTH-1] - {2'b00, divisor};

  always_comb begin
    if (trial[WIDTH+1]) begin
      stepNext = {remQuo[2*WIDTH-1:0], 1'b0};
    end else begin
      stepNext = {trial[WIDTH:0], remQuo[WIDTH-2:0], 1'b1};
    end
  end

  assign quoFix = quoNeg ? (~stepNext[WIDTH-1:0] + ONE) : stepNext[WIDTH-1:0];
  assign remFix = remNeg ? (~stepNext[2*WIDTH-1:WIDTH] + ONE)
                         : stepNext[2*WIDTH-1:WIDTH];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    stateNext = stateReg;
    stallComb = 1'b0;
    readyComb = 1'b0;
    case (stateReg)
      IDLE: begin
        stallComb = accept;
        if (accept) stateNext = BUSY;
      end
      BUSY: begin
        stallComb = 1'b1;
        if (lastIter) stateNext = DONE;
      end
      DONE: begin
        readyComb = 1'b1;
        if (bus.ack) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    if (bus.cancel) stateNext = IDLE;
  end

  // Datapath. A cancelled divide leaves stale contents behind; they are never
  // visible because result is only driven in DONE and IDLE reloads on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iterCnt <= '0;
      remQuo  <= '0;
      divisor <= '0;
      quoNeg  <= 1'b0;
      remNeg  <= 1'b0;
    end else if (stateReg == IDLE && accept) begin
      iterCnt <= '0;
      remQuo  <= {{(WIDTH+1){1'b0}}, absA};
      divisor <= absB;
      quoNeg  <= bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      remNeg  <= bus.sign & bus.a[WIDTH-1];
    end else if (stateReg == BUSY && !bus.cancel) begin
      iterCnt <= iterCnt + 1'b1;
      if (lastIter) begin
        remQuo <= {stepNext[2*WIDTH], remFix, quoFix};
      end else begin
        remQuo <= stepNext;
      end
    end
  end

  // Outputs are forced low while reset is held, including the start path.
  assign bus.stall  = rst & stallComb;
  assign bus.ready  = rst & readyComb;
  assign bus.result = (stateReg == DONE) ? remQuo[2*WIDTH-1:0] : '0;

endmodule

// File: tb/tb_div_radix2.sv
// tb_div_radix2
//   Directed bench for div_radix2: hand-computed vectors, latency, cancel,
//   DONE hold, and asynchronous reset behaviour.
module tb_div_radix2;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  div_radix2_if #(.WIDTH(32)) bus ();

  div_radix2 #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one divide at the next falling edge and follow it to DONE.
  // Stall is high in the request cycle plus 32 busy cycles, then ready.
  task automatic runDiv(input string tag, input logic s, input logic [31:0] da,
                        input logic [31:0] db, input logic [63:0] expRes);
    int busyOk;
    @(negedge clk);
    bus.start = 1'b1; bus.sign = s; bus.a = da; bus.b = db;
    #1;
    check({tag, " stall@start"}, 64'(bus.stall), 64'd1);
    busyOk = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if (bus.stall === 1'b1 && bus.ready === 1'b0) busyOk++;
    end
    check({tag, " busy cycles"}, 64'(busyOk), 64'd32);
    @(negedge clk);
    #1;
    check({tag, " ready"}, 64'({bus.ready, bus.stall}), 64'b10);
    check({tag, " result"}, bus.result, expRes);
  endtask

  task automatic doAck(input string tag);
    @(negedge clk);
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    #1;
    check({tag, " idle after ack"}, 64'({bus.ready, bus.stall}), 64'b00);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    bus.start = 1'b1; bus.sign = 1'b0; bus.a = 32'd100; bus.b = 32'd7;
    bus.cancel = 1'b0; bus.ack = 1'b0;

    // Reset: outputs low even with start asserted
    @(negedge clk); @(negedge clk);
    #1;
    check("reset stall", 64'(bus.stall), 64'd0);
    check("reset ready", 64'(bus.ready), 64'd0);
    check("reset result", bus.result, 64'd0);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Basic vectors
    runDiv("udiv 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
    doAck("udiv 100/7");
    runDiv("sdiv -7/2", 1'b1, 32'hFFFFFFF9, 32'h2, {32'hFFFFFFFF, 32'hFFFFFFFD});
    doAck("sdiv -7/2");
    runDiv("sdiv 7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD});
    doAck("sdiv 7/-2");
    runDiv("sdiv ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000});
    doAck("sdiv ovf");
    runDiv("udiv 5/0", 1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF});
    doAck("udiv 5/0");
    runDiv("sdiv -9/0", 1'b1, 32'hFFFFFFF7, 32'd0, {32'hFFFFFFF7, 32'h00000001});
    doAck("sdiv -9/0");
    runDiv("udiv max/16", 1'b0, 32'hFFFFFFFF, 32'h10, {32'h0000000F, 32'h0FFFFFFF});
    doAck("udiv max/16");

    // start and cancel together: stays idle
    @(negedge clk);
    bus.start = 1'b1; bus.cancel = 1'b1; bus.sign = 1'b0; bus.a = 32'd9; bus.b = 32'd3;
    #1;
    check("start+cancel stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0;
    #1;
    check("start+cancel idle", 64'({bus.ready, bus.stall}), 64'b00);

    // Cancel on BUSY cycle 10
    @(negedge clk);
    bus.start = 1'b1; bus.sign = 1'b0; bus.a = 32'd100; bus.b = 32'd7;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    #1;
    check("cancel idle", 64'({bus.ready, bus.stall}), 64'b00);
    @(negedge clk);
    #1;
    check("cancel no ready", 64'(bus.ready), 64'd0);
    runDiv("after cancel 1000/3", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333});

    // Hold in DONE for 3 cycles with a stray start pulse
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.start = (i == 1);
      bus.a = 32'd77; bus.b = 32'd5;
      #1;
      check($sformatf("done hold %0d", i), {bus.ready, bus.stall, bus.result[61:0]},
            {1'b1, 1'b0, 62'({32'd1, 32'd333})});
      check($sformatf("done result %0d", i), bus.result, {32'd1, 32'd333});
    end
    bus.start = 1'b0;
    // ack and cancel together in DONE
    @(negedge clk);
    bus.ack = 1'b1; bus.cancel = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0; bus.cancel = 1'b0;
    #1;
    check("ack+cancel idle", 64'({bus.ready, bus.stall}), 64'b00);
    check("ack+cancel result", bus.result, 64'd0);

    // Asynchronous reset during BUSY
    @(negedge clk);
    bus.start = 1'b1; bus.sign = 1'b0; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk); @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async rst outputs", {bus.result[61:0], bus.ready, bus.stall}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    runDiv("after rst 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
    doAck("after rst 100/7");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
